// File: rtl/buaa_pkg.sv
// rtl/buaa_pkg.sv - shared types and ctrl-word field layout for the BUAA scroll sequencer
//   Holds the FSM state enum, the bit positions of the ctrl bus fields, the length
//   of the blank phase and a helper that assembles an auto ctrl word.
package buaa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int OFS_LSB     = 0;
  localparam int OFS_MSB     = 2;
  localparam int OFS_W       = OFS_MSB - OFS_LSB + 1;
  localparam int BLANK_BIT   = 3;
  localparam int DIR_BIT     = 4;
  localparam int BLANK_TICKS = 2;

  // Bits [7:5] stay zero in the auto word.
  function automatic logic [7:0] pack_ctrl(input logic [OFS_W-1:0] ofs,
                                           input logic             blank,
                                           input logic             dir);
    logic [7:0] w;
    w                  = 8'h00;
    w[OFS_MSB:OFS_LSB] = ofs;
    w[BLANK_BIT]       = blank;
    w[DIR_BIT]         = dir;
    return w;
  endfunction

endpackage

// File: rtl/buaa_tick_gen.sv
// rtl/buaa_tick_gen.sv - programmable prescaler producing the scroll step tick
//   Counts 0..T-1 with T = PRESCALE >> speed_sel_i while en_i is high; holds otherwise.
//   Ports: clk, rst (sync, active high), clr_i (restart count at 0), en_i (count enable),
//          speed_sel_i[1:0] (period select), tick_o (combinational, high on the last count).
module buaa_tick_gen #(
  parameter int PRESCALE = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] speed_sel_i,
  output logic       tick_o
);

  localparam int CNT_W = $clog2(PRESCALE + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period;

  assign period = CNT_W'(PRESCALE >> speed_sel_i);

  // ">=" rather than "==": if speed_sel is raised while the count is already past the
  // new period, the count would otherwise run all the way round the counter.
  assign tick_o = en_i && (cnt_q >= period - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/buaa_scroll_ctrl.sv
// rtl/buaa_scroll_ctrl.sv - auto-scroll sequencer and ctrl-bus arbiter for the BUAA display
//   IDLE/RUN/PAUSE FSM steps a 3-bit rotation offset on each prescaler tick and drives a
//   registered ctrl word; a manual requester takes the bus and freezes sequencing.
//   Ports: clk, rst (sync, active high), start/stop (1-cycle pulses), dir, speed_sel[1:0],
//          manual_en, manual_ctrl[7:0], ctrl_o[7:0], busy, step_pulse.
//   Build option: BUAA_BLINK_EN adds a 2-tick blank phase after every offset wrap.
module buaa_scroll_ctrl
  import buaa_pkg::*;
#(
  parameter int PRESCALE = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic [1:0] speed_sel,
  input  logic       manual_en,
  input  logic [7:0] manual_ctrl,
  output logic [7:0] ctrl_o,
  output logic       busy,
  output logic       step_pulse
);

  state_e           state_q, state_d;
  logic [OFS_W-1:0] offset_q, offset_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic             step_q, step_d;
  logic             pre_clr, pre_en, tick;
  logic [OFS_W-1:0] next_ofs;
  logic             blank_bit;

  buaa_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (pre_clr),
    .en_i       (pre_en),
    .speed_sel_i(speed_sel),
    .tick_o     (tick)
  );

  // 3-bit arithmetic gives the 7->0 and 0->7 wrap for free.
  assign next_ofs = dir ? offset_q - OFS_W'(1) : offset_q + OFS_W'(1);

`ifdef BUAA_BLINK_EN
  logic [1:0] blank_q, blank_d;
  logic       wrap;

  assign wrap = dir ? (offset_q == '0) : (offset_q == '1);
`endif

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    pre_clr  = 1'b0;
    pre_en   = 1'b0;
`ifdef BUAA_BLINK_EN
    blank_d  = blank_q;
`endif
    // The manual requester freezes everything: no transitions, no counting.
    if (!manual_en) begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d  = ST_RUN;
            pre_clr  = 1'b1;
            offset_d = '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else begin
            pre_en = 1'b1;
            if (tick) begin
`ifdef BUAA_BLINK_EN
              // Ticks during the blank phase are consumed without moving the offset.
              if (blank_q != 2'd0) begin
                blank_d = blank_q - 2'd1;
              end else begin
                offset_d = next_ofs;
                if (wrap) blank_d = 2'(BLANK_TICKS);
              end
`else
              offset_d = next_ofs;
`endif
            end
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state_d  = ST_IDLE;
            offset_d = '0;
`ifdef BUAA_BLINK_EN
            blank_d  = 2'd0;
`endif
          end else if (start) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef BUAA_BLINK_EN
  assign blank_bit = (blank_d != 2'd0);
`else
  assign blank_bit = 1'b0;
`endif

  // Outputs are registered from next-state values so ctrl_o and step_pulse change together.
  assign step_d = pre_en && tick;
  assign ctrl_d = manual_en ? manual_ctrl : pack_ctrl(offset_d, blank_bit, dir);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      offset_q <= '0;
      ctrl_q   <= 8'h00;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      ctrl_q   <= ctrl_d;
      step_q   <= step_d;
    end
  end

`ifdef BUAA_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 2'd0;
    end else begin
      blank_q <= blank_d;
    end
  end
`endif

  assign ctrl_o     = ctrl_q;
  assign step_pulse = step_q;
  assign busy       = (state_q == ST_RUN);

endmodule

// File: tb/tb_buaa_scroll_ctrl.sv
// tb/tb_buaa_scroll_ctrl.sv - directed self-checking bench for buaa_scroll_ctrl (PRESCALE=8)
module tb_buaa_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       dir;
  logic [1:0] speed_sel;
  logic       manual_en;
  logic [7:0] manual_ctrl;
  logic [7:0] ctrl_o;
  logic       busy;
  logic       step_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  buaa_scroll_ctrl #(.PRESCALE(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .speed_sel  (speed_sel),
    .manual_en  (manual_en),
    .manual_ctrl(manual_ctrl),
    .ctrl_o     (ctrl_o),
    .busy       (busy),
    .step_pulse (step_pulse)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    total++; if (ctrl_o !== 8'h00) begin bad++; $display("FAIL reset_ctrl: got %h want 00", ctrl_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (step_pulse !== 1'b0) begin bad++; $display("FAIL reset_step: got %b want 0", step_pulse); end
    rst = 1'b0;
    cyc(1);
    total++; if (ctrl_o !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL post_reset: got ctrl=%h busy=%b want ctrl=00 busy=0", ctrl_o, busy); end
  endtask

  task automatic test_scroll;
    start = 1'b1; cyc(1); start = 1'b0;
    total++; if (busy !== 1'b1 || ctrl_o !== 8'h00) begin bad++; $display("FAIL scroll_start: got ctrl=%h busy=%b want ctrl=00 busy=1", ctrl_o, busy); end
    for (int k = 1; k <= 3; k++) begin
      cyc(7);
      total++; if (ctrl_o !== 8'(k - 1) || step_pulse !== 1'b0) begin bad++; $display("FAIL scroll_hold%0d: got ctrl=%h step=%b want ctrl=%h step=0", k, ctrl_o, step_pulse, 8'(k - 1)); end
      cyc(1);
      total++; if (ctrl_o !== 8'(k) || step_pulse !== 1'b1) begin bad++; $display("FAIL scroll_step%0d: got ctrl=%h step=%b want ctrl=%h step=1", k, ctrl_o, step_pulse, 8'(k)); end
    end
  endtask

  task automatic test_wrap;
    for (int i = 4; i <= 8; i++) begin
      cyc(8);
      total++; if (ctrl_o !== 8'(i % 8) || step_pulse !== 1'b1) begin bad++; $display("FAIL wrap_up%0d: got ctrl=%h step=%b want ctrl=%h step=1", i, ctrl_o, step_pulse, 8'(i % 8)); end
    end
    dir = 1'b1;
    cyc(1);
    total++; if (ctrl_o !== 8'h10 || step_pulse !== 1'b0) begin bad++; $display("FAIL dir_bit: got ctrl=%h step=%b want ctrl=10 step=0", ctrl_o, step_pulse); end
    cyc(7);
    total++; if (ctrl_o !== 8'h17 || step_pulse !== 1'b1) begin bad++; $display("FAIL wrap_down: got ctrl=%h step=%b want ctrl=17 step=1", ctrl_o, step_pulse); end
    cyc(8);
    total++; if (ctrl_o !== 8'h16) begin bad++; $display("FAIL dec_step: got %h want 16", ctrl_o); end
    dir = 1'b0;
    cyc(1);
    total++; if (ctrl_o !== 8'h06) begin bad++; $display("FAIL dir_clear: got %h want 06", ctrl_o); end
  endtask

  task automatic test_start_stop;
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    total++; if (busy !== 1'b0 || ctrl_o !== 8'h06) begin bad++; $display("FAIL run_stop_wins: got ctrl=%h busy=%b want ctrl=06 busy=0", ctrl_o, busy); end
    cyc(20);
    total++; if (ctrl_o !== 8'h06 || step_pulse !== 1'b0) begin bad++; $display("FAIL pause_hold: got ctrl=%h step=%b want ctrl=06 step=0", ctrl_o, step_pulse); end
    start = 1'b1; cyc(1); start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL resume_busy: got %b want 1", busy); end
    cyc(5);
    total++; if (ctrl_o !== 8'h06 || step_pulse !== 1'b0) begin bad++; $display("FAIL resume_hold: got ctrl=%h step=%b want ctrl=06 step=0", ctrl_o, step_pulse); end
    cyc(2);
    total++; if (ctrl_o !== 8'h07 || step_pulse !== 1'b1) begin bad++; $display("FAIL resume_step: got ctrl=%h step=%b want ctrl=07 step=1", ctrl_o, step_pulse); end
    stop = 1'b1; cyc(1); stop = 1'b0;
    total++; if (busy !== 1'b0 || ctrl_o !== 8'h07) begin bad++; $display("FAIL pause2: got ctrl=%h busy=%b want ctrl=07 busy=0", ctrl_o, busy); end
    stop = 1'b1; cyc(1); stop = 1'b0;
    total++; if (busy !== 1'b0 || ctrl_o !== 8'h00) begin bad++; $display("FAIL pause_clear: got ctrl=%h busy=%b want ctrl=00 busy=0", ctrl_o, busy); end
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    cyc(2);
    total++; if (busy !== 1'b0 || ctrl_o !== 8'h00) begin bad++; $display("FAIL idle_stop_wins: got ctrl=%h busy=%b want ctrl=00 busy=0", ctrl_o, busy); end
  endtask

  task automatic test_manual;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(8);
    total++; if (ctrl_o !== 8'h01 || step_pulse !== 1'b1) begin bad++; $display("FAIL man_pre: got ctrl=%h step=%b want ctrl=01 step=1", ctrl_o, step_pulse); end
    manual_en = 1'b1; manual_ctrl = 8'hA5;
    cyc(1);
    total++; if (ctrl_o !== 8'hA5 || busy !== 1'b1) begin bad++; $display("FAIL man_take: got ctrl=%h busy=%b want ctrl=a5 busy=1", ctrl_o, busy); end
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(18);
    total++; if (ctrl_o !== 8'hA5 || step_pulse !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL man_frozen: got ctrl=%h step=%b busy=%b want ctrl=a5 step=0 busy=1", ctrl_o, step_pulse, busy); end
    manual_en = 1'b0;
    cyc(1);
    total++; if (ctrl_o !== 8'h01 || busy !== 1'b1) begin bad++; $display("FAIL man_release: got ctrl=%h busy=%b want ctrl=01 busy=1", ctrl_o, busy); end
    cyc(6);
    total++; if (ctrl_o !== 8'h01 || step_pulse !== 1'b0) begin bad++; $display("FAIL man_resume_hold: got ctrl=%h step=%b want ctrl=01 step=0", ctrl_o, step_pulse); end
    cyc(1);
    total++; if (ctrl_o !== 8'h02 || step_pulse !== 1'b1) begin bad++; $display("FAIL man_resume_step: got ctrl=%h step=%b want ctrl=02 step=1", ctrl_o, step_pulse); end
  endtask

  task automatic test_speed;
    cyc(5);
    total++; if (ctrl_o !== 8'h02 || step_pulse !== 1'b0) begin bad++; $display("FAIL spd_pre: got ctrl=%h step=%b want ctrl=02 step=0", ctrl_o, step_pulse); end
    speed_sel = 2'd3;
    for (int i = 3; i <= 5; i++) begin
      cyc(1);
      total++; if (ctrl_o !== 8'(i) || step_pulse !== 1'b1) begin bad++; $display("FAIL spd_step%0d: got ctrl=%h step=%b want ctrl=%h step=1", i, ctrl_o, step_pulse, 8'(i)); end
    end
  endtask

  task automatic test_reset_mid;
    manual_en = 1'b1; manual_ctrl = 8'hA5; rst = 1'b1; speed_sel = 2'd0;
    cyc(1);
    total++; if (ctrl_o !== 8'h00 || busy !== 1'b0 || step_pulse !== 1'b0) begin bad++; $display("FAIL rst_mid: got ctrl=%h busy=%b step=%b want 00/0/0", ctrl_o, busy, step_pulse); end
    rst = 1'b0; manual_en = 1'b0;
    cyc(2);
    total++; if (ctrl_o !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL rst_after: got ctrl=%h busy=%b want ctrl=00 busy=0", ctrl_o, busy); end
  endtask

`ifdef BUAA_BLINK_EN
  task automatic test_blink;
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h08; exp_seq[1] = 8'h08; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(56);
    total++; if (ctrl_o !== 8'h07) begin bad++; $display("FAIL blink_pre: got %h want 07", ctrl_o); end
    for (int i = 0; i < 4; i++) begin
      cyc(8);
      total++; if (ctrl_o !== exp_seq[i] || step_pulse !== 1'b1) begin bad++; $display("FAIL blink_tick%0d: got ctrl=%h step=%b want ctrl=%h step=1", i, ctrl_o, step_pulse, exp_seq[i]); end
    end
    cyc(48);
    total++; if (ctrl_o !== 8'h07) begin bad++; $display("FAIL blink_pre2: got %h want 07", ctrl_o); end
    cyc(11);
    rst = 1'b1; cyc(1); rst = 1'b0;
    total++; if (ctrl_o !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL blink_rst: got ctrl=%h busy=%b want ctrl=00 busy=0", ctrl_o, busy); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; speed_sel = 2'd0;
    manual_en = 1'b0; manual_ctrl = 8'h00;
    test_reset;
`ifdef BUAA_BLINK_EN
    test_blink;
`else
    test_scroll;
    test_wrap;
    test_start_stop;
    test_manual;
    test_speed;
    test_reset_mid;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
